minterm_enumerator: RTL
=======================

// Module: minterm_enumerator
// PURPOSE
//  Upstream stimulus/collection stage for the Quine-McCluskey minimizer.
//  - Sweeps all 2^N_IN input vectors into a single-output combinational netlist (DUT).
//  - Samples the netlist output for each vector.
//  - Streams the index of every ON-set minterm, in ascending order, to the minimizer over a valid/ready interface.
//  - Buffers minterms in a small FIFO; stalls the sweep on backpressure.
// PARAMETERS
//  N_IN        13  number of netlist primary inputs (1..16)
//  FIFO_DEPTH  4   minterm output FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous active-low reset
//  start          in   1       1-cycle request to begin a sweep; ignored unless IDLE
//  vec_out        out  N_IN    input vector driven to netlist; bit 0 = first listed input
//  f_in           in   1       netlist output, combinational function of vec_out
//  m_valid        out  1       minterm available
//  m_ready        in   1       minimizer accepts minterm
//  m_index        out  N_IN    minterm index (= vec_out value that gave f_in=1)
//  m_last         out  1       with m_valid: this is the final minterm of the sweep
//  busy           out  1       high in SWEEP and DRAIN
//  done           out  1       1-cycle pulse, sweep complete and FIFO drained
//  minterm_count  out  N_IN+1  ON-set size of last/current sweep (up to 2^N_IN)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - vec_out=0, m_valid=0, m_last=0, busy=0, done=0, minterm_count=0.
//   - FIFO flushed, state=IDLE.
//   - Applies from any state; a sweep in progress is abandoned and no done pulse is issued.
//  FSM IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
//  IDLE:
//   - On start: vec_out<=0, minterm_count<=0, enter SWEEP.
//  SWEEP: each cycle f_in is sampled against the current registered vec_out.
//   - f_in=0: the vector advances.
//   - f_in=1 and FIFO not full: push vec_out, minterm_count+=1, then the vector advances.
//   - f_in=1 and FIFO full (after this cycle's pop): hold vec_out; no push; retry next cycle.
//   - A pop and a push in the same cycle on a full FIFO are both allowed.
//   - Vector advance: if vec_out == 2^N_IN-1, enter DRAIN with vec_out held; otherwise vec_out+1.
//     No wrap to 0.
//  DRAIN:
//   - No sampling.
//   - Exit to DONE in the cycle after the FIFO becomes empty.
//   - Exit immediately if the FIFO is already empty.
//  DONE:
//   - done=1 for exactly one cycle, then IDLE.
//   - vec_out returns to 0 in IDLE.
//   - minterm_count is held until the next start.
//  Output interface:
//   - m_valid = FIFO non-empty; m_index = FIFO head.
//   - A pop happens on m_valid & m_ready.
//   - m_index/m_valid are stable while m_valid & !m_ready.
//   - m_last=1 only on the head entry that is the final pushed minterm. That entry is tagged at push
//     time when vec_out == 2^N_IN-1, or at the DRAIN entry for the last FIFO entry.
//   - Empty ON-set: no m_valid at all; done still pulses with minterm_count=0.
//  Latency:
//   - Minimum sweep = 2^N_IN cycles in SWEEP with no stalls.
//   - A minterm pushed in cycle t is visible on m_valid in cycle t+1.
//  Widths: minterm_count is N_IN+1 bits, so the all-ones function (2^N_IN) does not overflow.
//  start while busy: ignored; no restart, no state change.
// TESTING
//  1. N_IN=3, f=majority(a,b,c), m_ready=1 -> m_index 3,5,6,7 in order; m_last only on 7;
//     done pulses; minterm_count=4.
//  2. N_IN=3, f=0 -> m_valid never asserts; done after 8 SWEEP cycles (+ DRAIN/DONE cycles);
//     minterm_count=0.
//  3. N_IN=3, f=1, m_ready=0 for 20 cycles -> vec_out stalls at 4 (FIFO_DEPTH=4); release ->
//     0..7 emitted with no loss or duplication; minterm_count=8.
//  4. N_IN=13 driving the 13-input ON-set netlist, random m_ready -> emitted set equals the
//     golden truth table ON-set; strictly ascending; exactly one m_last.
//  5. rst_n=0 mid-SWEEP with a non-empty FIFO -> next cycle all outputs are at reset values;
//     no done; a new start reproduces the full, correct sweep.
//  6. start pulsed during SWEEP and DRAIN -> no effect; single done; count unchanged.

Source files
------------

// File: rtl/minterm_enumerator.sv
// rtl/minterm_enumerator.sv - sweeps all input vectors of a netlist and streams ON-set minterm indices
//
// Purpose: drives every vector 0..2^N_IN-1 into a single-output combinational
// netlist, samples its output and pushes each ON-set index into a small FIFO
// that feeds the downstream minimizer over a valid/ready stream.  The sweep
// holds its vector whenever the FIFO cannot take a new minterm.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   start           one-cycle sweep request, honoured only when idle
//   vec_out         vector currently presented to the netlist
//   f_in            netlist response to vec_out
//   m_valid/m_ready/m_index/m_last   minterm stream to the minimizer
//   busy            sweeping or draining
//   done            one-cycle pulse once the sweep is complete and drained
//   minterm_count   ON-set size of the last/current sweep
module minterm_enumerator #(
  parameter int N_IN       = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            f_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N_IN-1:0] m_index,
  output logic            m_last,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   minterm_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};
  localparam logic [AW:0]     FILL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     FILL_ONE  = (AW+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   cnt_q, cnt_d;

  logic [N_IN-1:0]       idx_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem_q;
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [AW:0]           fill_q;

  logic sweeping, at_max, pop, push, full_after_pop, advance, tail_is_final;

  assign sweeping = (state_q == S_SWEEP);
  assign at_max   = (vec_q == VEC_MAX);

  assign m_valid = (fill_q != '0);
  assign m_index = idx_mem_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign full_after_pop = (fill_q == FILL_FULL) && !pop;
  assign push    = sweeping & f_in & !full_after_pop;
  assign advance = sweeping & (!f_in | push);

  // Once no further push can happen (draining, or the final vector is an
  // OFF-set vector), the single remaining entry is the final minterm even if
  // it was not tagged when pushed.
  assign tail_is_final = (fill_q == FILL_ONE) &&
                         ((state_q == S_DRAIN) || (sweeping && at_max && !f_in));
  assign m_last = m_valid & (last_mem_q[rd_ptr_q] | tail_is_final);

  assign vec_out       = vec_q;
  assign minterm_count = cnt_q;
  assign busy          = sweeping | (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          vec_d   = '0;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        if (push) cnt_d = cnt_q + 1'b1;
        if (advance) begin
          if (at_max) state_d = S_DRAIN;
          else        vec_d   = vec_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (fill_q == '0) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted in fill_q.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem_q[wr_ptr_q]  <= vec_q;
      last_mem_q[wr_ptr_q] <= at_max;
    end
  end

endmodule
